// File: rtl/mdeshuffle_pipe.sv
// Lane deshuffler: gathers one beat from every lane FIFO, reorders nibbles into
// sequential element order according to the head descriptor, and registers the result.
module mdeshuffle_pipe #(
  parameter int NrExits    = 4,
  parameter int LaneNb     = 4,
  parameter int LaneBufDep = 2,
  parameter int InfoBufDep = 4,
  parameter int CntW       = 8,
  parameter int IdW        = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NrExits-1:0]            rx_valid_i,
  output logic [NrExits-1:0]            rx_ready_o,
  input  logic [NrExits*4*LaneNb-1:0]   rx_data_i,
  input  logic                          info_valid_i,
  output logic                          info_ready_o,
  input  logic [1:0]                    info_sew_i,
  input  logic                          info_vm_i,
  input  logic [CntW-1:0]               info_cmt_cnt_i,
  input  logic [IdW-1:0]                info_req_id_i,
  input  logic                          mask_valid_i,
  input  logic [NrExits*LaneNb-1:0]     mask_i,
  output logic                          mask_ready_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [4*NrExits*LaneNb-1:0]   tx_nb_o,
  output logic [NrExits*LaneNb-1:0]     tx_en_o,
  output logic [IdW-1:0]                tx_req_id_o,
  output logic                          tx_last_o
);

  localparam int LaneW = 4 * LaneNb;
  localparam int NbTot = NrExits * LaneNb;
  localparam int LPtrW = (LaneBufDep > 1) ? $clog2(LaneBufDep) : 1;
  localparam int LCntW = $clog2(LaneBufDep + 1);
  localparam int IPtrW = $clog2(InfoBufDep);

  typedef struct packed {
    logic [1:0]      sew;
    logic            vm;
    logic [CntW-1:0] cmt_cnt;
    logic [IdW-1:0]  req_id;
  } info_t;

  logic                fire;
  logic                last_beat;
  logic [NrExits-1:0]  lane_empty;
  logic [LaneW-1:0]    head_beat [NrExits];
  logic [CntW-1:0]     beat_cnt;

  // ---------------------------------------------------------------- lane FIFOs
  for (genvar gl = 0; gl < NrExits; gl++) begin : g_lane
    logic [LaneW-1:0] mem [LaneBufDep];
    logic [LPtrW-1:0] wr_ptr;
    logic [LPtrW-1:0] rd_ptr;
    logic [LCntW-1:0] count;
    logic             push;

    assign rx_ready_o[gl] = (count != LCntW'(LaneBufDep));
    assign lane_empty[gl] = (count == '0);
    assign push           = rx_valid_i[gl] && rx_ready_o[gl] && !flush_i;
    assign head_beat[gl]  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wr_ptr] <= rx_data_i[gl*LaneW +: LaneW];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= (wr_ptr == LPtrW'(LaneBufDep - 1)) ? '0 : wr_ptr + 1'b1;
        end
        if (fire) begin
          rd_ptr <= (rd_ptr == LPtrW'(LaneBufDep - 1)) ? '0 : rd_ptr + 1'b1;
        end
        case ({push, fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- info queue
  info_t            info_mem [InfoBufDep];
  logic [IPtrW:0]   iwr_ptr;
  logic [IPtrW:0]   ird_ptr;
  logic             info_empty;
  logic             info_full;
  logic             info_push;
  logic             info_pop;
  info_t            head;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign info_empty   = (iwr_ptr == ird_ptr);
  assign info_full    = (iwr_ptr[IPtrW] != ird_ptr[IPtrW]) &&
                        (iwr_ptr[IPtrW-1:0] == ird_ptr[IPtrW-1:0]);
  assign info_ready_o = !info_full;
  assign info_push    = info_valid_i && !info_full && !flush_i;
  assign info_pop     = fire && last_beat;
  assign head         = info_mem[ird_ptr[IPtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (info_push) begin
      info_mem[iwr_ptr[IPtrW-1:0]] <= {info_sew_i, info_vm_i, info_cmt_cnt_i, info_req_id_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iwr_ptr <= '0;
      ird_ptr <= '0;
    end else if (flush_i) begin
      iwr_ptr <= '0;
      ird_ptr <= '0;
    end else begin
      if (info_push) iwr_ptr <= iwr_ptr + 1'b1;
      if (info_pop)  ird_ptr <= ird_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- fire logic
  assign fire = !flush_i && !(|lane_empty) && !info_empty &&
                (head.vm || mask_valid_i) && (!tx_valid_o || tx_ready_i);
  assign last_beat    = (beat_cnt == head.cmt_cnt);
  assign mask_ready_o = fire && !head.vm;

  // ---------------------------------------------------------------- deshuffle
  // Every element width gets its own fixed wiring; the head sew picks one.
  logic [3:0] map_nb [4][NbTot];
  logic       map_en [4][NbTot];

  for (genvar gw = 0; gw < 4; gw++) begin : g_sew
    localparam int ESz = 2 << gw;
    for (genvar gs = 0; gs < NbTot; gs++) begin : g_nb
      if (ESz <= LaneNb) begin : g_ok
        localparam int Elem = gs / ESz;
        localparam int Lane = Elem % NrExits;
        localparam int Off  = (Elem / NrExits) * ESz + (gs % ESz);
        assign map_nb[gw][gs] = head_beat[Lane][4*Off +: 4];
        assign map_en[gw][gs] = head.vm || mask_i[Lane*LaneNb + Off];
      end else begin : g_bad
        assign map_nb[gw][gs] = 4'h0;
        assign map_en[gw][gs] = 1'b0;
      end
    end
  end

  logic [4*NbTot-1:0] nb_next;
  logic [NbTot-1:0]   en_next;

  always_comb begin
    nb_next = '0;
    en_next = '0;
    for (int s = 0; s < NbTot; s++) begin
      nb_next[4*s +: 4] = map_nb[head.sew][s];
      en_next[s]        = map_en[head.sew][s];
    end
  end

  // ---------------------------------------------------------------- output stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_valid_o  <= 1'b0;
      tx_nb_o     <= '0;
      tx_en_o     <= '0;
      tx_req_id_o <= '0;
      tx_last_o   <= 1'b0;
      beat_cnt    <= '0;
    end else if (flush_i) begin
      tx_valid_o <= 1'b0;
      beat_cnt   <= '0;
    end else if (fire) begin
      tx_valid_o  <= 1'b1;
      tx_nb_o     <= nb_next;
      tx_en_o     <= en_next;
      tx_req_id_o <= head.req_id;
      tx_last_o   <= last_beat;
      beat_cnt    <= last_beat ? '0 : beat_cnt + 1'b1;
    end else if (tx_ready_i) begin
      tx_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdeshuffle_pipe.sv
// Randomized and directed bench for mdeshuffle_pipe, checked against a queue-based
// model that applies the element mapping rule directly.
module tb_mdeshuffle_pipe;
  localparam int NR = 4;
  localparam int LN = 4;
  localparam int LW = 4 * LN;
  localparam int NB = NR * LN;
  localparam int CW = 8;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [NR-1:0]   rx_valid = '0;
  logic [NR-1:0]   rx_ready;
  logic [NR*LW-1:0] rx_data = '0;
  logic            info_valid = 1'b0;
  logic            info_ready;
  logic [1:0]      info_sew = '0;
  logic            info_vm = 1'b0;
  logic [CW-1:0]   info_cnt = '0;
  logic [IW-1:0]   info_id = '0;
  logic            mask_valid = 1'b0;
  logic [NB-1:0]   mask = '0;
  logic            mask_ready;
  logic            tx_valid;
  logic            tx_ready = 1'b0;
  logic [4*NB-1:0] tx_nb;
  logic [NB-1:0]   tx_en;
  logic [IW-1:0]   tx_id;
  logic            tx_last;

  always #5 clk = ~clk;

  mdeshuffle_pipe #(
    .NrExits(NR), .LaneNb(LN), .LaneBufDep(2), .InfoBufDep(4), .CntW(CW), .IdW(IW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_data_i(rx_data),
    .info_valid_i(info_valid), .info_ready_o(info_ready), .info_sew_i(info_sew),
    .info_vm_i(info_vm), .info_cmt_cnt_i(info_cnt), .info_req_id_i(info_id),
    .mask_valid_i(mask_valid), .mask_i(mask), .mask_ready_o(mask_ready),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_nb_o(tx_nb), .tx_en_o(tx_en),
    .tx_req_id_o(tx_id), .tx_last_o(tx_last)
  );

  typedef struct packed {
    logic [1:0]    sew;
    logic          vm;
    logic [CW-1:0] cnt;
    logic [IW-1:0] id;
  } desc_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sequential nibble s comes from element s/E, which lives in lane (e % NR).
  function automatic void ref_beat(input logic [NR*LW-1:0] beats, input logic [1:0] sew,
                                   input logic vm, input logic [NB-1:0] mk,
                                   output logic [4*NB-1:0] nb, output logic [NB-1:0] en);
    int esz;
    esz = 2 << sew;
    nb = '0;
    en = '0;
    for (int s = 0; s < NB; s++) begin
      int e, k, lane, off;
      e = s / esz;
      k = s % esz;
      lane = e % NR;
      off = (e / NR) * esz + k;
      nb[4*s +: 4] = beats[lane*LW + 4*off +: 4];
      en[s] = vm | mk[lane*LN + off];
    end
  endfunction

  // ---------------------------------------------------------------- reference model
  logic [LW-1:0] m_lane [NR][$];
  desc_t         m_info [$];
  logic [NB-1:0] m_mask [$];
  int            m_beat = 0;
  int            tx_beats = 0;
  int            last_seen = 0;
  logic            hold_pend = 1'b0;
  logic [4*NB-1:0] h_nb;
  logic [NB-1:0]   h_en;
  logic [IW-1:0]   h_id;
  logic            h_last;

  function automatic logic model_empty();
    logic emp;
    emp = (m_info.size() == 0) && (m_mask.size() == 0);
    for (int l = 0; l < NR; l++) if (m_lane[l].size() != 0) emp = 1'b0;
    return emp;
  endfunction

  task automatic clear_model();
    for (int l = 0; l < NR; l++) m_lane[l].delete();
    m_info.delete();
    m_mask.delete();
    m_beat = 0;
  endtask

  task automatic check_beat();
    logic            starved;
    logic [NR*LW-1:0] beats;
    desc_t           d;
    logic [NB-1:0]   mk;
    logic [4*NB-1:0] enb;
    logic [NB-1:0]   een;
    logic            lst;
    starved = (m_info.size() == 0);
    for (int l = 0; l < NR; l++) if (m_lane[l].size() == 0) starved = 1'b1;
    d = '0;
    if (!starved) d = m_info[0];
    if (!starved && !d.vm && m_mask.size() == 0) starved = 1'b1;
    chk("tx_source", starved, 1'b0);
    if (!starved) begin
      for (int l = 0; l < NR; l++) beats[l*LW +: LW] = m_lane[l].pop_front();
      mk = '0;
      if (!d.vm) mk = m_mask.pop_front();
      ref_beat(beats, d.sew, d.vm, mk, enb, een);
      lst = (m_beat == int'(d.cnt));
      chk("tx_nb", tx_nb, enb);
      chk("tx_en", tx_en, een);
      chk("tx_id", tx_id, d.id);
      chk("tx_last", tx_last, lst);
      if (lst) begin
        void'(m_info.pop_front());
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    tx_beats++;
    if (tx_last) last_seen++;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      clear_model();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", tx_valid, 1'b1);
        chk("hold_nb", tx_nb, h_nb);
        chk("hold_en", tx_en, h_en);
        chk("hold_id", tx_id, h_id);
        chk("hold_last", tx_last, h_last);
      end
      hold_pend = tx_valid && !tx_ready && !flush;
      h_nb = tx_nb; h_en = tx_en; h_id = tx_id; h_last = tx_last;
      if (tx_valid && tx_ready) check_beat();
      if (flush) begin
        clear_model();
      end else begin
        for (int l = 0; l < NR; l++)
          if (rx_valid[l] && rx_ready[l]) m_lane[l].push_back(rx_data[l*LW +: LW]);
        if (info_valid && info_ready) begin
          if ((2 << info_sew) > LN) $error("illegal descriptor enqueued, sew=%0d", info_sew);
          m_info.push_back({info_sew, info_vm, info_cnt, info_id});
        end
        if (mask_valid && mask_ready) m_mask.push_back(mask);
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_info(input logic [1:0] sew, input logic vm, input int cnt, input int id);
    info_valid = 1'b1;
    info_sew = sew;
    info_vm = vm;
    info_cnt = CW'(cnt);
    info_id = IW'(id);
  endtask

  task automatic send_beat(input logic [NR*LW-1:0] d);
    logic acc;
    acc = 1'b0;
    rx_valid = '1;
    rx_data = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = &rx_ready;
      tick();
    end
    chk("send_accept", acc, 1'b1);
    rx_valid = '0;
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      tick();
      idle = !tx_valid && model_empty();
    end
    chk("drain_timeout", idle, 1'b1);
  endtask

  function automatic logic [NR*LW-1:0] rnd_beat();
    return {$urandom, $urandom};
  endfunction

  // ---------------------------------------------------------------- stimulus
  logic [LW-1:0] src_lane [NR][$];
  desc_t         src_info [$];

  initial begin
    logic [NR*LW-1:0] b0, b1, b2, b3;
    logic [4*NB-1:0]  enb;
    logic [NB-1:0]    een;
    int base, total, beats0;
    logic done, acc_i;
    logic [NR-1:0] acc_l;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_nb", tx_nb, '0);
    chk("rst_tx_en", tx_en, '0);
    chk("rst_tx_id", tx_id, '0);
    chk("rst_tx_last", tx_last, 1'b0);
    chk("rst_rx_ready", rx_ready, 4'hF);
    chk("rst_info_ready", info_ready, 1'b1);
    chk("rst_mask_ready", mask_ready, 1'b0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    tick();

    // sew=0, unmasked single beat
    set_info(2'd0, 1'b1, 0, 1);
    send_beat(64'hB3A3_B2A2_B1A1_B0A0);
    info_valid = 1'b0;
    tick();
    chk("sew0_valid", tx_valid, 1'b1);
    chk("sew0_nb", tx_nb, 64'hB3B2B1B0A3A2A1A0);
    chk("sew0_en", tx_en, 16'hFFFF);
    chk("sew0_last", tx_last, 1'b1);
    tick();

    // sew=1 with the same lane beats
    set_info(2'd1, 1'b1, 0, 2);
    send_beat(64'hB3A3_B2A2_B1A1_B0A0);
    info_valid = 1'b0;
    tick();
    chk("sew1_nb", tx_nb, 64'hB3A3B2A2B1A1B0A0);
    chk("sew1_id", tx_id, 4'd2);
    tick();

    // masked request waits for a mask beat
    b0 = rnd_beat();
    set_info(2'd1, 1'b0, 0, 3);
    send_beat(b0);
    info_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mask_wait_valid", tx_valid, 1'b0);
      chk("mask_wait_ready", mask_ready, 1'b0);
      tick();
    end
    mask_valid = 1'b1;
    mask = 16'h000F;
    #1;
    chk("mask_ready_on", mask_ready, 1'b1);
    tick();
    chk("mask_ready_pulse", mask_ready, 1'b0);
    chk("mask_valid", tx_valid, 1'b1);
    chk("mask_en", tx_en, 16'h000F);
    ref_beat(b0, 2'd1, 1'b0, 16'h000F, enb, een);
    chk("mask_nb", tx_nb, enb);
    mask_valid = 1'b0;
    tick();

    // backpressure mid-stream on a 4-beat request
    b0 = rnd_beat(); b1 = rnd_beat(); b2 = rnd_beat(); b3 = rnd_beat();
    base = last_seen;
    set_info(2'd1, 1'b1, 3, 4);
    send_beat(b0);
    info_valid = 1'b0;
    send_beat(b1);
    tx_ready = 1'b0;
    ref_beat(b0, 2'd1, 1'b1, '0, enb, een);
    chk("bp_first_valid", tx_valid, 1'b1);
    chk("bp_first_nb", tx_nb, enb);
    chk("bp_first_last", tx_last, 1'b0);
    rx_valid = '1;
    rx_data = b2;
    for (int i = 0; i < 3; i++) begin
      tick();
      rx_valid = '0;
      chk("bp_rx_full", rx_ready, 4'h0);
      chk("bp_hold_valid", tx_valid, 1'b1);
      chk("bp_hold_nb", tx_nb, enb);
    end
    tx_ready = 1'b1;
    send_beat(b3);
    wait_idle();
    chk("bp_one_last", last_seen - base, 1);

    // info queue full, then simultaneous enqueue and final-beat dequeue
    for (int i = 0; i < 4; i++) begin
      set_info(2'd0, 1'b1, 0, 8 + i);
      tick();
    end
    info_valid = 1'b0;
    chk("qf_full", info_ready, 1'b0);
    send_beat(rnd_beat());
    tick();
    chk("qf_after_pop", info_ready, 1'b1);
    send_beat(rnd_beat());
    set_info(2'd0, 1'b1, 0, 12);
    tick();
    info_valid = 1'b0;
    chk("qf_simul", info_ready, 1'b1);
    set_info(2'd0, 1'b1, 0, 13);
    tick();
    info_valid = 1'b0;
    chk("qf_refull", info_ready, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(rnd_beat());
    wait_idle();

    // flush with an output pending and one beat buffered per lane
    set_info(2'd1, 1'b1, 1, 5);
    send_beat(rnd_beat());
    info_valid = 1'b0;
    send_beat(rnd_beat());
    tx_ready = 1'b0;
    chk("fl_pre_valid", tx_valid, 1'b1);
    flush = 1'b1;
    rx_valid = '1;
    rx_data = rnd_beat();
    set_info(2'd0, 1'b1, 0, 6);
    tick();
    flush = 1'b0;
    rx_valid = '0;
    info_valid = 1'b0;
    chk("fl_valid", tx_valid, 1'b0);
    chk("fl_rx_ready", rx_ready, 4'hF);
    chk("fl_info_ready", info_ready, 1'b1);
    tx_ready = 1'b1;
    tick();
    tick();
    chk("fl_no_beat", tx_valid, 1'b0);
    base = last_seen;
    set_info(2'd0, 1'b1, 0, 7);
    send_beat(rnd_beat());
    info_valid = 1'b0;
    wait_idle();
    chk("fl_new_done", last_seen - base, 1);

    // randomized traffic
    total = 0;
    for (int r = 0; r < 40; r++) begin
      desc_t d;
      d.sew = 2'($urandom_range(0, 1));
      d.vm = 1'($urandom_range(0, 1));
      d.cnt = CW'($urandom_range(0, 3));
      d.id = IW'(r);
      src_info.push_back(d);
      total += int'(d.cnt) + 1;
      for (int b = 0; b <= int'(d.cnt); b++)
        for (int l = 0; l < NR; l++) src_lane[l].push_back(LW'($urandom));
    end
    beats0 = tx_beats;
    done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      acc_i = info_valid && info_ready;
      acc_l = rx_valid & rx_ready;
      tick();
      if (acc_i) void'(src_info.pop_front());
      for (int l = 0; l < NR; l++) if (acc_l[l]) void'(src_lane[l].pop_front());
      info_valid = 1'b0;
      if (src_info.size() != 0 && $urandom_range(0, 3) != 0) begin
        info_valid = 1'b1;
        {info_sew, info_vm, info_cnt, info_id} = src_info[0];
      end
      for (int l = 0; l < NR; l++) begin
        rx_valid[l] = (src_lane[l].size() != 0) && ($urandom_range(0, 3) != 0);
        if (src_lane[l].size() != 0) rx_data[l*LW +: LW] = src_lane[l][0];
      end
      mask_valid = ($urandom_range(0, 2) != 0);
      mask = NB'($urandom);
      tx_ready = ($urandom_range(0, 3) != 0);
      done = (src_info.size() == 0) && model_empty() && !tx_valid;
      for (int l = 0; l < NR; l++) if (src_lane[l].size() != 0) done = 1'b0;
    end
    info_valid = 1'b0;
    rx_valid = '0;
    mask_valid = 1'b0;
    tx_ready = 1'b1;
    chk("rnd_done", done, 1'b1);
    chk("rnd_beats", tx_beats - beats0, total);

    // asynchronous reset in the middle of a stalled request
    tx_ready = 1'b0;
    set_info(2'd1, 1'b1, 1, 9);
    send_beat(rnd_beat());
    info_valid = 1'b0;
    send_beat(rnd_beat());
    chk("arst_pre_valid", tx_valid, 1'b1);
    chk("arst_pre_id", tx_id, 4'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", tx_valid, 1'b0);
    chk("arst_tx_nb", tx_nb, '0);
    chk("arst_tx_en", tx_en, '0);
    chk("arst_tx_id", tx_id, '0);
    chk("arst_tx_last", tx_last, 1'b0);
    chk("arst_rx_ready", rx_ready, 4'hF);
    chk("arst_info_ready", info_ready, 1'b1);
    chk("arst_mask_ready", mask_ready, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    tick();
    chk("arst_after_valid", tx_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
